// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared types and helpers for the lsu_mmio_v2 load/store unit:
//   - access size and FSM state enums, region tag enum
//   - byte offsets of the mapped registers inside the output/input regions
//   - align_ok()  : natural-alignment check for a given size
//   - ld_extend() : byte/half select on addr[1:0] plus sign/zero extension
// ---------------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } lsu_state_e;

  typedef enum logic [1:0] {
    RG_NONE,
    RG_DMEM,
    RG_OUT,
    RG_IN
  } lsu_region_e;

  // Output region (64 bytes)
  localparam logic [5:0] OFS_LEDR = 6'h00;
  localparam logic [5:0] OFS_LEDG = 6'h10;
  localparam logic [5:0] OFS_HEX  = 6'h20;
  localparam logic [5:0] OFS_LCD  = 6'h30;

  // Input region (32 bytes)
  localparam logic [4:0] OFS_SW   = 5'h00;
  localparam logic [4:0] OFS_BTN  = 5'h10;
  localparam logic [4:0] OFS_BTNP = 5'h14;

  // Size 2'b11 is not a legal access and is reported as misaligned.
  function automatic logic align_ok(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_B:    align_ok = 1'b1;
      SZ_H:    align_ok = ~addr_lo[0];
      SZ_W:    align_ok = (addr_lo == 2'b00);
      default: align_ok = 1'b0;
    endcase
  endfunction

  // funct3[2] set means unsigned (zero-extend).
  function automatic logic [31:0] ld_extend(input logic [31:0] word,
                                            input logic [1:0]  addr_lo,
                                            input logic [2:0]  funct3);
    logic [31:0] sh;
    sh = word >> {addr_lo, 3'b000};
    case (funct3[1:0])
      SZ_B:    ld_extend = {{24{sh[7]  & ~funct3[2]}}, sh[7:0]};
      SZ_H:    ld_extend = {{16{sh[15] & ~funct3[2]}}, sh[15:0]};
      default: ld_extend = sh;
    endcase
  endfunction

endpackage

// File: rtl/lsu_sync.sv
// ---------------------------------------------------------------------------
// lsu_sync
// Multi-flop synchroniser for asynchronous board inputs.
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset, clears every stage
//   d_i    : asynchronous input  [WIDTH-1:0]
//   q_o    : synchronised output [WIDTH-1:0], STAGES cycles behind d_i
// ---------------------------------------------------------------------------
module lsu_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] ff_q [STAGES];

  // NOTE: sequential state is updated with <= so every stage samples the
  // previous stage's old value on the same edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) ff_q[i] <= '0;
    end else begin
      ff_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) ff_q[i] <= ff_q[i-1];
    end
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/lsu_mmio_v2.sv
// ---------------------------------------------------------------------------
// lsu_mmio_v2
// Handshaked load/store unit for the MEM stage: data RAM, 64-byte output
// MMIO region and a read-only, synchronised input MMIO region.
// One request in flight: IDLE -> ACCESS -> RESP -> IDLE.
//   clk_i / rst_i         clock, asynchronous active-high reset
//   req_*                 request channel (valid/ready), funct3 size+sign
//   resp_*                response channel (valid/ready), rdata + err
//   io_sw_i / io_btn_i    asynchronous board inputs
//   io_ledr_o/ledg/lcd    output region words, io_hex_o 7 bits per digit
// Optional feature macro: LSU_BTN_EDGE_EN -- adds W1C button-edge pending
// bits at IN+0x14.
// ---------------------------------------------------------------------------
module lsu_mmio_v2
  import lsu_pkg::*;
#(
  parameter int          DMEM_AW     = 13,
  parameter logic [15:0] DMEM_BASE   = 16'h2000,
  parameter logic [15:0] OUT_BASE    = 16'h7000,
  parameter logic [15:0] IN_BASE     = 16'h7800,
  parameter int          N_HEX       = 8,
  parameter int          SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_wren_i,
  input  logic [2:0]         req_funct3_i,
  input  logic [31:0]        req_addr_i,
  input  logic [31:0]        req_wdata_i,
  output logic               resp_valid_o,
  input  logic               resp_ready_i,
  output logic [31:0]        resp_rdata_o,
  output logic               resp_err_o,
  input  logic [31:0]        io_sw_i,
  input  logic [3:0]         io_btn_i,
  output logic [31:0]        io_ledr_o,
  output logic [31:0]        io_ledg_o,
  output logic [7*N_HEX-1:0] io_hex_o,
  output logic [31:0]        io_lcd_o
);

  localparam int WORDS = 2 ** (DMEM_AW - 2);

  lsu_state_e state_q, state_d;

  // ---------------- request decode ----------------
  logic [1:0]  req_lo;
  logic        hit_dmem, hit_out, hit_in, btnp_wr_ok, req_fault;
  logic        accept, do_write;
  lsu_region_e req_region;
  logic [3:0]  req_be;
  logic [31:0] req_wlane;

  assign req_lo   = req_addr_i[1:0];
  assign hit_dmem = (req_addr_i[15:DMEM_AW] == DMEM_BASE[15:DMEM_AW]);
  assign hit_out  = (req_addr_i[15:6] == OUT_BASE[15:6]);
  assign hit_in   = (req_addr_i[15:5] == IN_BASE[15:5]);

  always_comb begin
    if (hit_dmem)     req_region = RG_DMEM;
    else if (hit_out) req_region = RG_OUT;
    else if (hit_in)  req_region = RG_IN;
    else              req_region = RG_NONE;
  end

`ifdef LSU_BTN_EDGE_EN
  assign btnp_wr_ok = (req_addr_i[4:2] == OFS_BTNP[4:2]);
`else
  assign btnp_wr_ok = 1'b0;
`endif

  // The input region is read-only except for the W1C pending word.
  assign req_fault = !align_ok(req_funct3_i[1:0], req_lo)
                   || (req_region == RG_NONE)
                   || (req_wren_i && (req_region == RG_IN) && !btnp_wr_ok);

  // NOTE: combinational blocks assign every output first so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    case (req_funct3_i[1:0])
      SZ_B:    req_be = 4'b0001 << req_lo;
      SZ_H:    req_be = 4'b0011 << req_lo;
      default: req_be = 4'b1111;
    endcase
    req_wlane = req_wdata_i << {req_lo, 3'b000};
  end

  assign accept   = req_valid_i && req_ready_o;
  assign do_write = accept && req_wren_i && !req_fault;

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = ACCESS;
      end
      ACCESS: state_d = RESP;
      RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- data RAM ----------------
  logic [31:0] dmem [WORDS];
  logic [31:0] ram_rd_q;
  logic [DMEM_AW-1:0] addr_q;

  // NOTE: the RAM array and its read register carry no reset so the
  // tools can map them onto block RAM.
  always_ff @(posedge clk_i) begin
    if (do_write && (req_region == RG_DMEM)) begin
      for (int b = 0; b < 4; b++)
        if (req_be[b]) dmem[req_addr_i[DMEM_AW-1:2]][8*b +: 8] <= req_wlane[8*b +: 8];
    end
    if (state_q == ACCESS) ram_rd_q <= dmem[addr_q[DMEM_AW-1:2]];
  end

  // ---------------- output region ----------------
  logic [7:0] out_q [64];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 64; i++) out_q[i] <= '0;
    end else if (do_write && (req_region == RG_OUT)) begin
      for (int b = 0; b < 4; b++)
        if (req_be[b]) out_q[{req_addr_i[5:2], 2'(b)}] <= req_wlane[8*b +: 8];
    end
  end

  assign io_ledr_o = {out_q[OFS_LEDR | 6'd3], out_q[OFS_LEDR | 6'd2],
                      out_q[OFS_LEDR | 6'd1], out_q[OFS_LEDR]};
  assign io_ledg_o = {out_q[OFS_LEDG | 6'd3], out_q[OFS_LEDG | 6'd2],
                      out_q[OFS_LEDG | 6'd1], out_q[OFS_LEDG]};
  assign io_lcd_o  = {out_q[OFS_LCD | 6'd3], out_q[OFS_LCD | 6'd2],
                      out_q[OFS_LCD | 6'd1], out_q[OFS_LCD]};

  for (genvar k = 0; k < N_HEX; k++) begin : g_hex
    assign io_hex_o[7*k +: 7] = out_q[OFS_HEX + 6'(k)][6:0];
  end

  // ---------------- input region ----------------
  logic [31:0] sw_sync;
  logic [3:0]  btn_sync, btn_pend;

  lsu_sync #(.WIDTH(32), .STAGES(SYNC_STAGES)) u_sync_sw (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (io_sw_i),
    .q_o   (sw_sync)
  );

  lsu_sync #(.WIDTH(4), .STAGES(SYNC_STAGES)) u_sync_btn (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (io_btn_i),
    .q_o   (btn_sync)
  );

`ifdef LSU_BTN_EDGE_EN
  logic [3:0] btn_prev_q, btn_pend_q, btn_clr;

  // Only the pending word is writable in the input region, so any
  // completed input-region store is a W1C write to it.
  assign btn_clr = (do_write && (req_region == RG_IN) && req_be[0]) ? req_wlane[3:0] : 4'b0;

  // A rising edge in the same cycle as a clear wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      btn_prev_q <= '0;
      btn_pend_q <= '0;
    end else begin
      btn_prev_q <= btn_sync;
      btn_pend_q <= (btn_pend_q & ~btn_clr) | (btn_sync & ~btn_prev_q);
    end
  end

  assign btn_pend = btn_pend_q;
`else
  assign btn_pend = 4'b0;
`endif

  // ---------------- access / response registers ----------------
  logic [2:0]  funct3_q;
  logic        wren_q, err_q;
  lsu_region_e region_q;
  logic [31:0] mmio_rd_q, out_word, in_word, rd_word;

  assign out_word = {out_q[{addr_q[5:2], 2'd3}], out_q[{addr_q[5:2], 2'd2}],
                     out_q[{addr_q[5:2], 2'd1}], out_q[{addr_q[5:2], 2'd0}]};

  always_comb begin
    case (addr_q[4:2])
      OFS_SW[4:2]:   in_word = sw_sync;
      OFS_BTN[4:2]:  in_word = {28'b0, btn_sync};
      OFS_BTNP[4:2]: in_word = {28'b0, btn_pend};
      default:       in_word = 32'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q    <= '0;
      funct3_q  <= '0;
      wren_q    <= 1'b0;
      err_q     <= 1'b0;
      region_q  <= RG_NONE;
      mmio_rd_q <= '0;
    end else begin
      if (accept) begin
        addr_q   <= req_addr_i[DMEM_AW-1:0];
        funct3_q <= req_funct3_i;
        wren_q   <= req_wren_i;
        err_q    <= req_fault;
        region_q <= req_region;
      end
      if (state_q == ACCESS) mmio_rd_q <= (region_q == RG_OUT) ? out_word : in_word;
    end
  end

  assign rd_word      = (region_q == RG_DMEM) ? ram_rd_q : mmio_rd_q;
  assign resp_rdata_o = (resp_valid_o && !err_q && !wren_q)
                      ? ld_extend(rd_word, addr_q[1:0], funct3_q) : 32'b0;
  assign resp_err_o   = resp_valid_o && err_q;

  // Upper address bits do not take part in decoding.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr_i[31:16];

endmodule

// File: tb/tb_lsu_mmio_v2.sv
// ---------------------------------------------------------------------------
// tb_lsu_mmio_v2
// Directed, table-driven bench for lsu_mmio_v2 plus hand-written sequences
// for MMIO outputs, synchronised inputs, backpressure and mid-flight reset.
// Honours LSU_BTN_EDGE_EN when the design is built with it.
// ---------------------------------------------------------------------------
module tb_lsu_mmio_v2;

  localparam int N_HEX       = 8;
  localparam int SYNC_STAGES = 2;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b0;
  logic               req_valid_i, req_ready_o, req_wren_i;
  logic [2:0]         req_funct3_i;
  logic [31:0]        req_addr_i, req_wdata_i;
  logic               resp_valid_o, resp_ready_i, resp_err_o;
  logic [31:0]        resp_rdata_o;
  logic [31:0]        io_sw_i;
  logic [3:0]         io_btn_i;
  logic [31:0]        io_ledr_o, io_ledg_o, io_lcd_o;
  logic [7*N_HEX-1:0] io_hex_o;

  always #5 clk_i = ~clk_i;

  lsu_mmio_v2 #(.N_HEX(N_HEX), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_wren_i   (req_wren_i),
    .req_funct3_i (req_funct3_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_rdata_o (resp_rdata_o),
    .resp_err_o   (resp_err_o),
    .io_sw_i      (io_sw_i),
    .io_btn_i     (io_btn_i),
    .io_ledr_o    (io_ledr_o),
    .io_ledg_o    (io_ledg_o),
    .io_hex_o     (io_hex_o),
    .io_lcd_o     (io_lcd_o)
  );

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_X = 3'b011;
  localparam logic [2:0] F_BU = 3'b100, F_HU = 3'b101;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_er;
  } vec_t;

  vec_t vt[$];

  task automatic add(input string name, input logic wr, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, input logic exp_er);
    vec_t v;
    v.name = name; v.wr = wr; v.f3 = f3; v.addr = addr;
    v.wdata = wdata; v.exp_rd = exp_rd; v.exp_er = exp_er;
    vt.push_back(v);
  endtask

  // One full transaction with resp_ready_i held high; checks ready,
  // two-cycle latency, rdata and err.
  task automatic txn(input string name, input logic wr, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, input logic exp_er);
    int cyc;
    @(negedge clk_i);
    check({name, " req_ready"}, {31'b0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1; req_wren_i = wr; req_funct3_i = f3;
    req_addr_i = addr; req_wdata_i = wdata;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk_i);
      cyc++;
    end while (!resp_valid_o && cyc < 8);
    check({name, " latency"}, 32'(cyc), 32'd2);
    check({name, " rdata"}, resp_rdata_o, exp_rd);
    check({name, " err"}, {31'b0, resp_err_o}, {31'b0, exp_er});
    @(posedge clk_i); #1;
  endtask

  initial begin
    logic [31:0] held;
    int cyc;

    req_valid_i = 0; req_wren_i = 0; req_funct3_i = 0; req_addr_i = 0; req_wdata_i = 0;
    resp_ready_i = 1; io_sw_i = 0; io_btn_i = 0;

    // ---------------- reset ----------------
    #1 rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("rst req_ready", {31'b0, req_ready_o}, 32'd1);
    check("rst resp_valid", {31'b0, resp_valid_o}, 32'd0);
    check("rst rdata", resp_rdata_o, 32'd0);
    check("rst err", {31'b0, resp_err_o}, 32'd0);
    check("rst ledr", io_ledr_o, 32'd0);
    check("rst hex lo", io_hex_o[31:0], 32'd0);
    rst_i = 1'b0;

    // ---------------- table ----------------
    add("sw_2000",     1, F_W,  32'h2000, 32'h1234_5678, 32'h0,          0);
    add("lbu_2003",    0, F_BU, 32'h2003, 32'h0,         32'h0000_0012,  0);
    add("lb_2003",     0, F_B,  32'h2003, 32'h0,         32'h0000_0012,  0);
    add("lh_2002",     0, F_H,  32'h2002, 32'h0,         32'h0000_1234,  0);
    add("lw_2000",     0, F_W,  32'h2000, 32'h0,         32'h1234_5678,  0);
    add("sb_2001",     1, F_B,  32'h2001, 32'h0000_0080, 32'h0,          0);
    add("lb_2001",     0, F_B,  32'h2001, 32'h0,         32'hFFFF_FF80,  0);
    add("lbu_2001",    0, F_BU, 32'h2001, 32'h0,         32'h0000_0080,  0);
    add("lw_2000_b",   0, F_W,  32'h2000, 32'h0,         32'h1234_8078,  0);
    add("lw_mis_2002", 0, F_W,  32'h2002, 32'h0,         32'h0,          1);
    add("sh_mis_2001", 1, F_H,  32'h2001, 32'h0000_BEEF, 32'h0,          1);
    add("lw_2000_c",   0, F_W,  32'h2000, 32'h0,         32'h1234_8078,  0);
    add("sh_2006",     1, F_H,  32'h2006, 32'hFFFF_8001, 32'h0,          0);
    add("lh_2006",     0, F_H,  32'h2006, 32'h0,         32'hFFFF_8001,  0);
    add("lhu_2006",    0, F_HU, 32'h2006, 32'h0,         32'h0000_8001,  0);
    add("size11",      0, F_X,  32'h2000, 32'h0,         32'h0,          1);
    add("unmapped",    0, F_W,  32'h4000, 32'h0,         32'h0,          1);
    add("sw_top",      1, F_W,  32'h3FFC, 32'hA1B2_C3D4, 32'h0,          0);
    add("lh_top",      0, F_H,  32'h3FFE, 32'h0,         32'hFFFF_A1B2,  0);
    add("sw_in_ro",    1, F_W,  32'h7800, 32'h1111_2222, 32'h0,          1);
    add("sw_ledr",     1, F_W,  32'h7000, 32'hDEAD_BEEF, 32'h0,          0);
    add("lw_ledr",     0, F_W,  32'h7000, 32'h0,         32'hDEAD_BEEF,  0);
    add("sb_hex3",     1, F_B,  32'h7023, 32'h0000_003F, 32'h0,          0);
    add("lbu_hex3",    0, F_BU, 32'h7023, 32'h0,         32'h0000_003F,  0);
    add("sw_scratch",  1, F_W,  32'h703C, 32'hCAFE_F00D, 32'h0,          0);
    add("lw_scratch",  0, F_W,  32'h703C, 32'h0,         32'hCAFE_F00D,  0);
    add("lw_btnp_idle",0, F_W,  32'h7814, 32'h0,         32'h0,          0);
    for (int i = 0; i < vt.size(); i++)
      txn(vt[i].name, vt[i].wr, vt[i].f3, vt[i].addr, vt[i].wdata, vt[i].exp_rd, vt[i].exp_er);

    // ---------------- output ports ----------------
    @(negedge clk_i);
    check("io_ledr", io_ledr_o, 32'hDEAD_BEEF);
    check("io_hex3", {25'b0, io_hex_o[3*7 +: 7]}, 32'h3F);
    check("io_hex2", {25'b0, io_hex_o[2*7 +: 7]}, 32'h0);
    check("io_ledg", io_ledg_o, 32'h0);
    check("io_lcd", io_lcd_o, 32'h0);

    // ---------------- synchronised inputs ----------------
    io_sw_i = 32'hA5A5_0F0F; io_btn_i = 4'b1010;
    repeat (SYNC_STAGES + 1) @(posedge clk_i);
    txn("lw_sw", 0, F_W, 32'h7800, 32'h0, 32'hA5A5_0F0F, 0);
    txn("lbu_btn", 0, F_BU, 32'h7810, 32'h0, 32'h0000_000A, 0);
    txn("lw_in_gap", 0, F_W, 32'h7808, 32'h0, 32'h0, 0);
    io_btn_i = 4'b0;
    repeat (SYNC_STAGES + 2) @(posedge clk_i);

    // ---------------- backpressure ----------------
    @(negedge clk_i);
    resp_ready_i = 1'b0;
    req_valid_i = 1'b1; req_wren_i = 1'b0; req_funct3_i = F_W; req_addr_i = 32'h2000;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk_i);
      cyc++;
    end while (!resp_valid_o && cyc < 8);
    check("bp latency", 32'(cyc), 32'd2);
    held = resp_rdata_o;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("bp resp_valid", {31'b0, resp_valid_o}, 32'd1);
      check("bp rdata", resp_rdata_o, 32'h1234_8078);
      check("bp req_ready", {31'b0, req_ready_o}, 32'd0);
    end
    check("bp rdata held", resp_rdata_o, held);
    resp_ready_i = 1'b1;
    @(negedge clk_i);
    check("bp released valid", {31'b0, resp_valid_o}, 32'd0);
    check("bp released ready", {31'b0, req_ready_o}, 32'd1);

    // ---------------- reset during ACCESS ----------------
    @(negedge clk_i);
    req_valid_i = 1'b1; req_wren_i = 1'b1; req_funct3_i = F_W;
    req_addr_i = 32'h2010; req_wdata_i = 32'h55AA_55AA;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0; req_wren_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    check("rst_mid resp_valid", {31'b0, resp_valid_o}, 32'd0);
    check("rst_mid req_ready", {31'b0, req_ready_o}, 32'd1);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_mid dropped", {31'b0, resp_valid_o}, 32'd0);
    check("rst_mid ledr cleared", io_ledr_o, 32'd0);
    txn("rst_mid write kept", 0, F_W, 32'h2010, 32'h0, 32'h55AA_55AA, 0);

    // ---------------- button edge pending ----------------
`ifdef LSU_BTN_EDGE_EN
    @(negedge clk_i);
    io_btn_i = 4'b0100;
    repeat (4) @(negedge clk_i);
    io_btn_i = 4'b0000;
    repeat (SYNC_STAGES + 2) @(negedge clk_i);
    txn("btnp set", 0, F_W, 32'h7814, 32'h0, 32'h0000_0004, 0);
    txn("btnp w1c", 1, F_B, 32'h7814, 32'h0000_0004, 32'h0, 0);
    txn("btnp cleared", 0, F_W, 32'h7814, 32'h0, 32'h0, 0);
`else
    @(negedge clk_i);
    io_btn_i = 4'b0100;
    repeat (4) @(negedge clk_i);
    io_btn_i = 4'b0000;
    repeat (SYNC_STAGES + 2) @(negedge clk_i);
    txn("btnp absent", 0, F_W, 32'h7814, 32'h0, 32'h0, 0);
    txn("btnp store faults", 1, F_B, 32'h7814, 32'h0000_0004, 32'h0, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so a stuck design still ends the run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
